// File: rtl/full_adder_if.sv
// Operand/result bundle for the single-bit full adder cell.
// slave is the adder side; master is the driver/observer side.
interface full_adder_if;
  logic A;
  logic B;
  logic Cin;
  logic ser_en;
  logic Sum;
  logic Cout;
  logic Sum_q;
  logic Cout_q;

  modport slave  (input  A, B, Cin, ser_en, output Sum, Cout, Sum_q, Cout_q);
  modport master (output A, B, Cin, ser_en, input  Sum, Cout, Sum_q, Cout_q);
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder with a combinational result and a registered copy.
// In serial mode the registered carry feeds back as carry-in (LSB-first add).
module full_adder (
  input  logic         clk,
  input  logic         rst_n,
  full_adder_if.slave  fa
);

  logic ci;
  logic sum_d, cout_d;
  logic sum_q, cout_q;

  // cout_q doubles as the serial carry register
  always_comb begin
    ci     = fa.ser_en ? cout_q : fa.Cin;
    sum_d  = fa.A ^ fa.B ^ ci;
    cout_d = (fa.A & fa.B) | (fa.A & ci) | (fa.B & ci);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign fa.Sum    = sum_d;
  assign fa.Cout   = cout_d;
  assign fa.Sum_q  = sum_q;
  assign fa.Cout_q = cout_q;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: A+B+ci reference model with a
// scoreboard queue holding the expected registered result for each vector.
module tb_full_adder;

  logic clk;
  logic rst_n;
  full_adder_if fa_if();

  full_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fa    (fa_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [1:0] sb_q[$];   // expected {Cout_q, Sum_q} after the next edge
  logic       m_cq;      // model of the carry register

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Called at posedge+1: drive a vector, check the combinational path,
  // queue the registered expectation, then check it after the next edge.
  task automatic step(input string tag, input logic a, input logic b,
                      input logic cin, input logic ser);
    logic       ci;
    logic [1:0] e;
    logic [1:0] r;
    fa_if.A = a; fa_if.B = b; fa_if.Cin = cin; fa_if.ser_en = ser;
    #2;
    ci = ser ? m_cq : cin;
    e  = {1'b0, a} + {1'b0, b} + {1'b0, ci};
    chk({tag, "_comb"}, {fa_if.Cout, fa_if.Sum}, e);
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 2'b00, 2'b11);
    end else begin
      r = sb_q.pop_front();
      chk({tag, "_reg"}, {fa_if.Cout_q, fa_if.Sum_q}, r);
      m_cq = r[1];
    end
  endtask

  initial begin
    fa_if.A = 1'b0; fa_if.B = 1'b0; fa_if.Cin = 1'b0; fa_if.ser_en = 1'b0;
    rst_n = 1'b0;
    m_cq  = 1'b0;
    #12;
    chk("reset_regs", {fa_if.Cout_q, fa_if.Sum_q}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // exhaustive combinational sweep, normal mode
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      step($sformatf("exh%0d", i), v[2], v[1], v[0], 1'b0);
    end

    // registered path holds between edges
    step("reg111", 1'b1, 1'b1, 1'b1, 1'b0);
    fa_if.A = 1'b0; fa_if.B = 1'b0; fa_if.Cin = 1'b0;
    #2;
    chk("reg_hold_comb", {fa_if.Cout, fa_if.Sum}, 2'b00);
    chk("reg_hold_q", {fa_if.Cout_q, fa_if.Sum_q}, 2'b11);
    @(posedge clk); #1;
    chk("reg_hold_next", {fa_if.Cout_q, fa_if.Sum_q}, 2'b00);
    m_cq = 1'b0;

    // serial 3 + 1 after reset; Cin=1 must be ignored in serial mode
    rst_n = 1'b0; #1; rst_n = 1'b1; m_cq = 1'b0;
    step("ser0", 1'b1, 1'b1, 1'b1, 1'b1);
    step("ser1", 1'b1, 1'b0, 1'b1, 1'b1);
    step("ser2", 1'b0, 1'b0, 1'b1, 1'b1);

    // async reset mid-cycle with Cout_q = 1
    step("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_cq", {1'b0, fa_if.Cout_q}, 2'b01);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {fa_if.Cout_q, fa_if.Sum_q}, 2'b00);
    m_cq = 1'b0;
    fa_if.A = 1'b0; fa_if.B = 1'b0; fa_if.Cin = 1'b1; fa_if.ser_en = 1'b1;
    #1;
    chk("rst_ser_00", {fa_if.Cout, fa_if.Sum}, 2'b00);
    fa_if.A = 1'b1; fa_if.B = 1'b1;
    #1;
    chk("rst_ser_11", {fa_if.Cout, fa_if.Sum}, 2'b10);
    @(posedge clk); #1;
    chk("rst_held", {fa_if.Cout_q, fa_if.Sum_q}, 2'b00);
    rst_n = 1'b1;

    // random regression, mixing modes mid-stream
    for (int i = 0; i < 16; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      step($sformatf("rnd%0d", i), r[3], r[2], r[1], r[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
